bolme_denetleyici: RTL
======================

// Module: bolme_denetleyici
// PURPOSE
//  Issue/result controller sitting directly upstream of the 32-bit divider in the execute stage.
//  Decodes RV32M DIV/DIVU/REM/REMU, captures operands, pulses the divider request, and holds sign stable for the whole operation.
//  Selects quotient or remainder and returns one tagged result pulse to writeback; absorbs pipeline flushes while the divider runs.
// PARAMETERS
//  YAZMAC_W   5   destination-register tag width
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   synchronous reset, active-high
//  istek_i          in   1   valid division request from execute
//  islem_i          in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//  rs1_i            in   32  dividend
//  rs2_i            in   32  divisor
//  hedef_i          in   YAZMAC_W  destination tag
//  iptal_i          in   1   pipeline flush
//  mesgul_o         out  1   high = request not accepted this cycle
//  bolme_istek_o    out  1   divider request pulse
//  bolme_sign_o     out  1   divider signed select; 1 = signed
//  bolunen_o        out  32  divider dividend
//  bolen_o          out  32  divider divisor
//  bolum_i          in   32  divider quotient
//  kalan_i          in   32  divider remainder
//  bolme_hazir_i    in   1   divider one-cycle result pulse
//  sonuc_o          out  32  selected result
//  sonuc_gecerli_o  out  1   one-cycle result-valid pulse
//  hedef_o          out  YAZMAC_W  tag of sonuc_o
// BEHAVIOUR
//  - Reset: state BOS; all outputs 0; mesgul_o = 0; cache (if built) invalid.
//  - Handshake: a request transfers when istek_i && !mesgul_o && !iptal_i. Upstream holds its request while mesgul_o is high.
//  - mesgul_o = (state != BOS). This is a combinational decode of the registered state.
//  - FSM transitions:
//    - BOS -> ISTEK on transfer. Capture rs1, rs2, tag, islem[1] (rem select) and the signed flag (~islem[0]).
//    - ISTEK: bolme_istek_o = 1 for exactly this one cycle -> BEKLE.
//    - BEKLE: wait for bolme_hazir_i; then latch bolum_i or kalan_i into sonuc_o -> SONUC.
//    - SONUC: sonuc_gecerli_o = 1 for one cycle -> BOS. The next request can issue no earlier than the cycle after SONUC.
//    - IPTAL: wait for bolme_hazir_i, discard the result, emit no pulse -> BOS.
//  - bolunen_o, bolen_o and bolme_sign_o are driven from registers. They hold stable from ISTEK until the divider pulses hazir.
//  - Divider latency is variable. Minimum latency = 1 cycle (zero-divisor, unsigned-small and overflow fast paths).
//  - No timeout: BEKLE and IPTAL wait indefinitely for bolme_hazir_i.
//  - Overhead: transfer cycle -> ISTEK +1 cycle; hazir sampled -> sonuc_gecerli_o +1 cycle.
//  - The controller passes RISC-V corner results through unmodified:
//    - x/0: q = FFFFFFFF, r = x.
//    - 80000000 / FFFFFFFF signed: q = 80000000, r = 0.
//  - Flush:
//    - iptal_i in ISTEK or BEKLE -> IPTAL. The in-flight divide runs to completion and its result is dropped.
//    - iptal_i in SONUC suppresses sonuc_gecerli_o; state still goes -> BOS.
//    - iptal_i with istek_i in BOS: flush wins, nothing is accepted.
//  - bolme_hazir_i in BOS or ISTEK is ignored (spurious pulse).
//  - Reset mid-operation returns to BOS. The divider is reset by the same rst_i.
// CONFIGURATION
//  - BOLME_ONBELLEK_EN defined: one-entry cache of {rs1, rs2, signed, quotient, remainder}.
//    - Filled at SONUC, or at IPTAL completion, from the divider outputs.
//    - A transfer whose rs1, rs2 and signed flag all match a valid entry goes BOS -> SONUC directly.
//    - That hit path produces sonuc_gecerli_o on the next cycle, with no divider request.
//    - Typical use: DIV followed by REM on the same operands.
//    - Entry invalidated only by reset.
//  - BOLME_ONBELLEK_EN not defined: no cache logic; every request goes through ISTEK/BEKLE.
// TESTING
//  - DIVU 100/7: bolme_istek_o pulses once; sonuc_gecerli_o pulses once with sonuc_o = 0000000E and hedef_o = tag.
//  - REM -7/2 (FFFFFFF9, 00000002): sonuc_o = FFFFFFFF. DIV same operands: sonuc_o = FFFFFFFD. bolme_sign_o stays 1 throughout.
//  - DIV 80000000/FFFFFFFF -> 80000000. REMU 5/0 -> 00000005. DIVU 5/0 -> FFFFFFFF.
//  - iptal_i in the 3rd BEKLE cycle: no sonuc_gecerli_o; mesgul_o stays high until hazir +1 cycle. A following DIVU 9/3 returns 00000003.
//  - Back-to-back: istek_i held high across two requests. The second bolme_istek_o comes no earlier than 2 cycles after the first hazir.
//  - BOLME_ONBELLEK_EN: DIV 50/7 then REM 50/7 -> second result 00000001 one cycle after transfer, no bolme_istek_o. Without the macro: a full divider round-trip.

Source files
------------

// File: rtl/bolme_denetleyici_if.sv
// Bus between the execute stage, the divide controller and the 32-bit divider.
// The slave modport is the controller's view; the master modport is the surrounding pipeline and divider.
interface bolme_denetleyici_if #(
  parameter int YAZMAC_W = 5
);
  // Request handshake: a request transfers on a clock edge where
  // istek_i && !mesgul_o && !iptal_i; the requester keeps istek_i and its
  // operands steady while mesgul_o is high.
  logic                istek_i;
  logic [1:0]          islem_i;
  logic [31:0]         rs1_i;
  logic [31:0]         rs2_i;
  logic [YAZMAC_W-1:0] hedef_i;
  logic                iptal_i;
  logic                mesgul_o;
  logic                bolme_istek_o;
  logic                bolme_sign_o;
  logic [31:0]         bolunen_o;
  logic [31:0]         bolen_o;
  logic [31:0]         bolum_i;
  logic [31:0]         kalan_i;
  logic                bolme_hazir_i;
  logic [31:0]         sonuc_o;
  logic                sonuc_gecerli_o;
  logic [YAZMAC_W-1:0] hedef_o;

  modport slave (
    input  istek_i, islem_i, rs1_i, rs2_i, hedef_i, iptal_i,
    input  bolum_i, kalan_i, bolme_hazir_i,
    output mesgul_o, bolme_istek_o, bolme_sign_o, bolunen_o, bolen_o,
    output sonuc_o, sonuc_gecerli_o, hedef_o
  );

  modport master (
    output istek_i, islem_i, rs1_i, rs2_i, hedef_i, iptal_i,
    output bolum_i, kalan_i, bolme_hazir_i,
    input  mesgul_o, bolme_istek_o, bolme_sign_o, bolunen_o, bolen_o,
    input  sonuc_o, sonuc_gecerli_o, hedef_o
  );
endinterface

// File: rtl/bolme_denetleyici.sv
// RV32M DIV/DIVU/REM/REMU issue/result controller in front of a variable-latency divider.
// Optional one-entry result cache enabled by defining BOLME_ONBELLEK_EN.
module bolme_denetleyici #(
  parameter int YAZMAC_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bolme_denetleyici_if.slave  bus,
  output logic [2:0]          durum_o
);
  localparam logic [2:0] BOS   = 3'd0;
  localparam logic [2:0] ISTEK = 3'd1;
  localparam logic [2:0] BEKLE = 3'd2;
  localparam logic [2:0] SONUC = 3'd3;
  localparam logic [2:0] IPTAL = 3'd4;

  logic [2:0]          durum;
  logic [31:0]         bolunen;
  logic [31:0]         bolen;
  logic                sign;
  logic                kalan_sec;
  logic [31:0]         sonuc;
  logic [YAZMAC_W-1:0] hedef;
  logic                aktarim;
  logic                isabet;
  logic [31:0]         isabet_sonuc;

  assign aktarim = bus.istek_i && (durum == BOS) && !bus.iptal_i;

`ifdef BOLME_ONBELLEK_EN
  logic        onb_gecerli;
  logic [31:0] onb_q;
  logic [31:0] onb_r;

  // The operand registers double as the cache key: they are only rewritten
  // by a transfer, and a fill always happens while they hold that op's operands.
  assign isabet = onb_gecerli && (bus.rs1_i == bolunen) && (bus.rs2_i == bolen)
                  && (sign == ~bus.islem_i[0]);
  assign isabet_sonuc = bus.islem_i[1] ? onb_r : onb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      onb_gecerli <= 1'b0;
      onb_q       <= 32'h0;
      onb_r       <= 32'h0;
    end else if (bus.bolme_hazir_i && (durum == BEKLE || durum == IPTAL)) begin
      onb_gecerli <= 1'b1;
      onb_q       <= bus.bolum_i;
      onb_r       <= bus.kalan_i;
    end
  end
`else
  assign isabet       = 1'b0;
  assign isabet_sonuc = 32'h0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum     <= BOS;
      bolunen   <= 32'h0;
      bolen     <= 32'h0;
      sign      <= 1'b0;
      kalan_sec <= 1'b0;
      sonuc     <= 32'h0;
      hedef     <= '0;
    end else begin
      case (durum)
        BOS: begin
          if (aktarim) begin
            bolunen   <= bus.rs1_i;
            bolen     <= bus.rs2_i;
            sign      <= ~bus.islem_i[0];
            kalan_sec <= bus.islem_i[1];
            hedef     <= bus.hedef_i;
            if (isabet) begin
              sonuc <= isabet_sonuc;
              durum <= SONUC;
            end else begin
              durum <= ISTEK;
            end
          end
        end
        ISTEK: durum <= bus.iptal_i ? IPTAL : BEKLE;
        BEKLE: begin
          // A flush landing on the hazir cycle drops the result directly.
          if (bus.bolme_hazir_i) begin
            if (bus.iptal_i) begin
              durum <= BOS;
            end else begin
              sonuc <= kalan_sec ? bus.kalan_i : bus.bolum_i;
              durum <= SONUC;
            end
          end else if (bus.iptal_i) begin
            durum <= IPTAL;
          end
        end
        SONUC: durum <= BOS;
        IPTAL: if (bus.bolme_hazir_i) durum <= BOS;
        default: durum <= BOS;
      endcase
    end
  end

  assign bus.mesgul_o        = (durum != BOS);
  assign bus.bolme_istek_o   = (durum == ISTEK);
  assign bus.sonuc_gecerli_o = (durum == SONUC) && !bus.iptal_i;
  assign bus.bolme_sign_o    = sign;
  assign bus.bolunen_o       = bolunen;
  assign bus.bolen_o         = bolen;
  assign bus.sonuc_o         = sonuc;
  assign bus.hedef_o         = hedef;
  assign durum_o             = durum;
endmodule
